// File: rtl/mem_arbiter.sv
// Core/DMA arbiter in front of one memory port with a fixed access latency of WAIT_CYCLES+1 cycles.
// Optional macro ARB_ROUND_ROBIN_EN: tie-break by round robin instead of fixed core priority.

module mem_arbiter_port (
  input  logic        clk,
  input  logic        reset,
  input  logic        cap,
  input  logic [31:0] ReadData,
  output logic [31:0] rdata
);
  always_ff @(posedge clk or posedge reset)
    if (reset)    rdata <= '0;
    else if (cap) rdata <= ReadData;
endmodule

module mem_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_adr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        MemWrite,
  output logic [31:0] Adr,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);
  localparam int   NUM_PORTS = 2;
  localparam logic CORE      = 1'b0;
  localparam logic DMA       = 1'b1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                     state, state_nxt;
  logic [3:0]                 cnt, cnt_nxt;
  logic                       owner, owner_nxt;
  logic                       last_grant, last_nxt;
  logic                       grant;
  logic [NUM_PORTS-1:0]       req, we, ready;
  logic [NUM_PORTS-1:0][31:0] adr, wdata, rdata;

  assign req   = {d_req, c_req};
  assign we    = {d_we, c_we};
  assign adr   = {d_adr, c_adr};
  assign wdata = {d_wdata, c_wdata};

`ifdef ARB_ROUND_ROBIN_EN
  // On a tie the port that did not finish last wins; otherwise the lone requester.
  assign grant = (&req) ? ~last_grant : ~req[CORE];
`else
  assign grant = ~req[CORE];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= CORE;
      last_grant <= DMA;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      owner      <= owner_nxt;
      last_grant <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    owner_nxt = owner;
    last_nxt  = last_grant;
    ready     = '0;
    MemWrite  = 1'b0;
    Adr       = '0;
    WriteData = '0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          owner_nxt = grant;
          cnt_nxt   = 4'(WAIT_CYCLES);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // Owner's inputs are followed live; requesters keep them stable until ready.
        Adr       = adr[owner];
        WriteData = wdata[owner];
        if (cnt == '0) begin
          ready[owner] = 1'b1;
          MemWrite     = we[owner];
          last_nxt     = owner;
          state_nxt    = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    mem_arbiter_port u_port (
      .clk      (clk),
      .reset    (reset),
      .cap      (ready[p] & ~we[p]),
      .ReadData (ReadData),
      .rdata    (rdata[p])
    );
  end

  assign c_ready = ready[CORE];
  assign d_ready = ready[DMA];
  assign c_rdata = rdata[CORE];
  assign d_rdata = rdata[DMA];

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level timing model (grant -> completion at grant cycle + 1 + WAIT_CYCLES).

module tb_mem_arbiter;
  localparam int W  = 1;
  localparam int W3 = 3;

  logic              clk, reset;
  logic [1:0]        req, we;
  logic [1:0][31:0]  adr, wdata;
  logic [31:0]       c_rdata, d_rdata, Adr, WriteData, ReadData;
  logic              c_ready, d_ready, MemWrite;

  logic              s_req, s_we;
  logic [31:0]       s_adr, s_wdata, s_c_rdata, s_d_rdata, s_Adr, s_WriteData, s_ReadData;
  logic              s_c_ready, s_d_ready, s_MemWrite;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  assign ReadData   = memf(Adr);
  assign s_ReadData = memf(s_Adr);

  mem_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset),
    .c_req(req[0]), .c_we(we[0]), .c_adr(adr[0]), .c_wdata(wdata[0]),
    .c_rdata(c_rdata), .c_ready(c_ready),
    .d_req(req[1]), .d_we(we[1]), .d_adr(adr[1]), .d_wdata(wdata[1]),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData)
  );

  mem_arbiter #(.WAIT_CYCLES(W3)) dut3 (
    .clk(clk), .reset(reset),
    .c_req(s_req), .c_we(s_we), .c_adr(s_adr), .c_wdata(s_wdata),
    .c_rdata(s_c_rdata), .c_ready(s_c_ready),
    .d_req(1'b0), .d_we(1'b0), .d_adr(32'h0), .d_wdata(32'h0),
    .d_rdata(s_d_rdata), .d_ready(s_d_ready),
    .MemWrite(s_MemWrite), .Adr(s_Adr), .WriteData(s_WriteData), .ReadData(s_ReadData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    reset = 1'b1; req = '0; we = '0; adr = '0; wdata = '0;
    s_req = 1'b0; s_we = 1'b0; s_adr = '0; s_wdata = '0;
    #3;
    total++; if ({c_ready, d_ready, MemWrite} !== 3'b000) begin bad++; $display("FAIL rst_strobes got=%b want=000", {c_ready, d_ready, MemWrite}); end
    total++; if (Adr !== 32'h0) begin bad++; $display("FAIL rst_adr got=%h want=0", Adr); end
    total++; if (WriteData !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h want=0", WriteData); end
    total++; if (c_rdata !== 32'h0 || d_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h/%h want=0/0", c_rdata, d_rdata); end
    @(posedge clk); #1; reset = 1'b0;
  endtask

  task automatic test_core_read();
    @(posedge clk); #1; req[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h10; wdata[0] = '0;
    @(negedge clk);
    total++; if (c_ready !== 1'b0) begin bad++; $display("FAIL rd_cyc0_ready got=%b want=0", c_ready); end
    @(negedge clk);
    total++; if (c_ready !== 1'b0 || Adr !== 32'h10) begin bad++; $display("FAIL rd_cyc1 got ready=%b adr=%h want 0/10", c_ready, Adr); end
    @(negedge clk);
    total++; if (c_ready !== 1'b1 || MemWrite !== 1'b0 || d_ready !== 1'b0) begin bad++; $display("FAIL rd_cyc2 got c=%b mw=%b d=%b want 1/0/0", c_ready, MemWrite, d_ready); end
    @(posedge clk); #1; req[0] = 1'b0;
    total++; if (c_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h want=deadbeef", c_rdata); end
    total++; if (d_rdata !== 32'h0) begin bad++; $display("FAIL rd_other got=%h want=0", d_rdata); end
    @(negedge clk);
    total++; if (c_ready !== 1'b0) begin bad++; $display("FAIL rd_single_pulse got=%b want=0", c_ready); end
  endtask

  task automatic test_dma_write();
    int pulses = 0;
    int at = -1;
    @(posedge clk); #1; req[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h20; wdata[1] = 32'h12345678;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (MemWrite) begin
        pulses++; at = i;
        total++; if (Adr !== 32'h20 || WriteData !== 32'h12345678 || d_ready !== 1'b1) begin
          bad++; $display("FAIL wr_pulse got adr=%h wd=%h d_ready=%b want 20/12345678/1", Adr, WriteData, d_ready); end
      end
      if (d_ready) begin @(posedge clk); #1; req[1] = 1'b0; we[1] = 1'b0; end
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL wr_count got=%0d want=1", pulses); end
    total++; if (at !== 2) begin bad++; $display("FAIL wr_latency got=%0d want=2", at); end
    total++; if (d_rdata !== 32'h0 || c_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rdata got=%h/%h want deadbeef/0", c_rdata, d_rdata); end
  endtask

  task automatic test_both();
    int n = 0;
    int dcnt = 0;
    logic [3:0] got = '0;
    logic [3:0] want;
`ifdef ARB_ROUND_ROBIN_EN
    want = 4'b1010;
`else
    want = 4'b0000;
`endif
    @(posedge clk); #1; req = 2'b11; we = 2'b00; adr[0] = 32'h100; adr[1] = 32'h200;
    for (int i = 0; i < 16 && n < 4; i++) begin
      @(negedge clk);
      total++; if (c_ready && d_ready) begin bad++; $display("FAIL both_dual_ready got=11 want one-hot"); end
      if (c_ready) begin got[n] = 1'b0; n++; end
      else if (d_ready) begin got[n] = 1'b1; n++; dcnt++; end
    end
    @(posedge clk); #1; req = 2'b00;
    total++; if (n !== 4) begin bad++; $display("FAIL both_timeout got=%0d grants want=4", n); end
    total++; if (got !== want) begin bad++; $display("FAIL both_order got=%b want=%b", got, want); end
    total++; if (c_rdata !== memf(32'h100)) begin bad++; $display("FAIL both_crdata got=%h want=%h", c_rdata, memf(32'h100)); end
`ifndef ARB_ROUND_ROBIN_EN
    total++; if (dcnt !== 0) begin bad++; $display("FAIL both_dma_starved got=%0d want=0", dcnt); end
`else
    total++; if (d_rdata !== memf(32'h200)) begin bad++; $display("FAIL both_drdata got=%h want=%h", d_rdata, memf(32'h200)); end
`endif
  endtask

  task automatic test_reset_mid();
    int wp = 0;
    int pulses = 0;
    bit seen = 1'b0;
    @(posedge clk); #1; req[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h40; wdata[0] = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1; #1;
    total++; if (MemWrite !== 1'b0 || c_ready !== 1'b0) begin bad++; $display("FAIL rmid_strobes got mw=%b rdy=%b want 0/0", MemWrite, c_ready); end
    total++; if (Adr !== 32'h0 || WriteData !== 32'h0) begin bad++; $display("FAIL rmid_bus got %h/%h want 0/0", Adr, WriteData); end
    total++; if (c_rdata !== 32'h0 || d_rdata !== 32'h0) begin bad++; $display("FAIL rmid_rdata got %h/%h want 0/0", c_rdata, d_rdata); end
    repeat (2) begin @(negedge clk); if (MemWrite || c_ready) wp++; end
    total++; if (wp !== 0) begin bad++; $display("FAIL rmid_held got=%0d strobes want=0", wp); end
    @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (MemWrite) pulses++;
      if (c_ready) begin
        seen = 1'b1;
        total++; if (MemWrite !== 1'b1 || Adr !== 32'h40 || WriteData !== 32'hCAFEF00D) begin
          bad++; $display("FAIL rmid_regrant got mw=%b adr=%h wd=%h want 1/40/cafef00d", MemWrite, Adr, WriteData); end
      end
    end
    @(posedge clk); #1; req[0] = 1'b0; we[0] = 1'b0;
    total++; if (!seen || pulses !== 1) begin bad++; $display("FAIL rmid_complete got seen=%b pulses=%0d want 1/1", seen, pulses); end
  endtask

  task automatic test_slow();
    @(posedge clk); #1; s_req = 1'b1; s_we = 1'b0; s_adr = 32'h80; s_wdata = 32'h55;
    @(negedge clk);
    total++; if (s_c_ready !== 1'b0 || s_Adr !== 32'h0) begin bad++; $display("FAIL slow_idle got rdy=%b adr=%h want 0/0", s_c_ready, s_Adr); end
    @(posedge clk); #1; s_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      total++; if (s_Adr !== 32'h80 || s_WriteData !== 32'h55 || s_c_ready !== (i == 4) || s_MemWrite !== 1'b0 || s_d_ready !== 1'b0) begin
        bad++; $display("FAIL slow_cyc%0d got adr=%h wd=%h rdy=%b mw=%b want 80/55/%0d/0", i, s_Adr, s_WriteData, s_c_ready, s_MemWrite, (i == 4)); end
    end
    @(posedge clk); #1;
    total++; if (s_c_rdata !== memf(32'h80) || s_d_rdata !== 32'h0) begin bad++; $display("FAIL slow_rdata got=%h/%h want=%h/0", s_c_rdata, s_d_rdata, memf(32'h80)); end
    @(negedge clk);
    total++; if (s_c_ready !== 1'b0 || s_Adr !== 32'h0) begin bad++; $display("FAIL slow_back_idle got rdy=%b adr=%h want 0/0", s_c_ready, s_Adr); end
  endtask

  task automatic test_random(input int ncyc);
    int t = 0;
    int done = 0;
    bit busy = 1'b0;
    bit own = 1'b0;
    bit last = 1'b1;
    bit [1:0] act = '0;
    logic [1:0][31:0] mrd = '0;
    logic [1:0] exp_rdy;
    logic exp_mw;
    logic [31:0] exp_adr, exp_wd;
    @(posedge clk); #1; reset = 1'b1; req = '0; we = '0;
    @(posedge clk); #1; reset = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (!act[p]) begin
          if ($urandom_range(0, 2) != 0) begin
            act[p] = 1'b1; req[p] = 1'b1; we[p] = 1'($urandom_range(0, 1));
            adr[p] = 32'($urandom_range(0, 63)) << 2; wdata[p] = $urandom;
          end else req[p] = 1'b0;
        end else if (busy && own == p && $urandom_range(0, 3) == 0) req[p] = 1'b0;
      end
      @(negedge clk);
      exp_rdy = '0; exp_mw = 1'b0; exp_adr = '0; exp_wd = '0;
      if (busy) begin
        exp_adr = adr[own]; exp_wd = wdata[own];
        if (t == done) begin exp_rdy[own] = 1'b1; exp_mw = we[own]; end
      end
      total++; if ({d_ready, c_ready} !== exp_rdy || MemWrite !== exp_mw) begin
        bad++; $display("FAIL rnd_strobe t=%0d got rdy=%b mw=%b want rdy=%b mw=%b", t, {d_ready, c_ready}, MemWrite, exp_rdy, exp_mw); end
      total++; if (Adr !== exp_adr || WriteData !== exp_wd) begin
        bad++; $display("FAIL rnd_bus t=%0d got %h/%h want %h/%h", t, Adr, WriteData, exp_adr, exp_wd); end
      total++; if (c_rdata !== mrd[0] || d_rdata !== mrd[1]) begin
        bad++; $display("FAIL rnd_rdata t=%0d got %h/%h want %h/%h", t, c_rdata, d_rdata, mrd[0], mrd[1]); end
      if (busy && t == done) begin
        if (!we[own]) mrd[own] = memf(adr[own]);
        last = own; busy = 1'b0; act[own] = 1'b0;
      end else if (!busy && req != 2'b00) begin
`ifdef ARB_ROUND_ROBIN_EN
        own = (req == 2'b11) ? !last : !req[0];
`else
        own = !req[0];
`endif
        busy = 1'b1; done = t + 1 + W;
      end
      t++;
    end
    @(posedge clk); #1; req = '0;
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_dma_write();
    test_both();
    test_reset_mid();
    test_slow();
    test_random(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, memory access cycles before completion (legal range 1..15).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 c_req, c_we  input  1 each  core access request and write enable.
REQ-005 c_adr, c_wdata  input  32 each  core address and write data.
REQ-006 c_rdata  output  32  registered core read data; c_ready output 1, one-cycle completion pulse.
REQ-007 d_req, d_we  input  1 each  DMA/debug request and write enable.
REQ-008 d_adr, d_wdata  input  32 each  DMA address and write data.
REQ-009 d_rdata  output  32  registered DMA read data; d_ready output 1, one-cycle completion pulse.
REQ-010 MemWrite  output  1; Adr, WriteData  output  32 each; ReadData  input  32 (combinational memory read).

Function
REQ-011 FSM states: IDLE, BUSY; 4-bit wait counter; 1-bit owner register; 1-bit last_grant register.
REQ-012 IDLE: no request -> stay IDLE, Adr/WriteData = 0, MemWrite = 0.
REQ-013 IDLE with request(s): pick owner per REQ-020/021, load counter = WAIT_CYCLES, go BUSY next cycle.
REQ-014 BUSY: Adr/WriteData driven from owner's inputs every cycle; counter decrements by 1 per cycle.
REQ-015 BUSY with counter == 0: owner's ready = 1 for that cycle only; MemWrite = owner's we only in that cycle; ReadData captured into owner's rdata register on that edge for reads; owner updates last_grant; next state IDLE.
REQ-016 Latency: request seen in IDLE at cycle N -> ready at cycle N+1+WAIT_CYCLES; minimum one IDLE cycle between consecutive grants.
REQ-017 Non-owner ready held 0; non-owner rdata unchanged; writes never update rdata.
REQ-018 Requesters hold req/we/adr/wdata stable until ready; a req dropped during BUSY does not abort -- transaction completes and ready still pulses.
REQ-019 New requests arriving during BUSY wait; they are evaluated only in IDLE.

Configuration
REQ-020 Macro ARB_ROUND_ROBIN_EN defined: simultaneous c_req and d_req -> grant the port not equal to last_grant; single request -> grant it.
REQ-021 Macro undefined: fixed priority, core always wins ties; last_grant still updated but unused.

Reset
REQ-022 reset asserted (any cycle, including mid-BUSY): state = IDLE, counter = 0, owner = core, last_grant = DMA, c_ready = d_ready = 0, MemWrite = 0, c_rdata = d_rdata = 0, within the same cycle (asynchronous).
REQ-023 Aborted write during reset never produces a MemWrite pulse; first grant after reset release follows REQ-020/021 with last_grant = DMA.

Verification
REQ-024 WAIT_CYCLES=1, core read adr 0x10, ReadData=0xDEADBEEF -> c_ready at cycle 2 after req, c_rdata = 0xDEADBEEF, d_rdata stays 0.
REQ-025 DMA write adr 0x20 wdata 0x12345678 -> exactly one MemWrite pulse with Adr=0x20, WriteData=0x12345678, coincident with d_ready.
REQ-026 Both req held continuously, macro defined -> grants alternate C,D,C,D; macro undefined -> core granted every transaction, d_ready never pulses.
REQ-027 reset pulsed during BUSY of a core write -> no MemWrite, no ready, outputs zero; after release, pending core req re-granted and completes normally.
REQ-028 WAIT_CYCLES=3, core read with c_req dropped after one cycle -> Adr held stable 4 cycles, c_ready pulses at cycle 4, FSM returns IDLE.
